count_seq_monitor: RTL
======================

Name: count_seq_monitor

Overview:
- Receive-side checker for the wrapping up/down counter bus (default range 2..5).
- Samples the counter's Count output and infers the count direction.
- Locks onto the sequence once enough consistent steps are seen, and flags and counts illegal transitions.
- Sits downstream of the counter, in the same clock domain.

Parameters:
WIDTH, 3, width of CountIn
MIN_VAL, 2, lowest legal count value
MAX_VAL, 5, highest legal count value; MAX_VAL-MIN_VAL must be >=2 so up and down steps are distinguishable
LOCK_STEPS, 3, consecutive same-direction legal steps required to lock
ERRW, 8, width of ErrCount

Ports:
Clk  input  1  clock; all state updates on the rising edge (the counter updates on the falling edge, so CountIn is stable at the rising edge)
nReset  input  1  asynchronous, active-low reset
Sample  input  1  qualifies CountIn this cycle; no state change when 0
CountIn  input  WIDTH  observed counter value
ClrErr  input  1  synchronous clear of ErrCount
Locked  output  1  sequence locked
Dir  output  1  1=up, 0=down; meaningful only when Locked=1
DirChange  output  1  one-cycle pulse: direction reversed while locked
SeqError  output  1  one-cycle pulse: illegal sample
ErrCount  output  ERRW  saturating count of illegal samples

Behaviour:
- Reset (async, nReset=0):
  - State=EMPTY, Prev=MIN_VAL, StepCnt=0, Cand=1.
  - Outputs: Locked=0, Dir=1, DirChange=0, SeqError=0, ErrCount=0.
  - Reset mid-operation discards all history immediately.
- All outputs are registered. Latency is one rising edge from a sampled input to the visible output.
- DirChange and SeqError are 0 on any cycle without a qualifying event, including Sample=0 cycles.
- Definitions:
  - InRange = MIN_VAL<=CountIn<=MAX_VAL.
  - NxtUp(p) = (p==MAX_VAL)?MIN_VAL:p+1.
  - NxtDn(p) = (p==MIN_VAL)?MAX_VAL:p-1.
- Sample classification against Prev:
  - HOLD: CountIn==Prev.
  - UP: CountIn==NxtUp(Prev).
  - DN: CountIn==NxtDn(Prev).
  - ILLEGAL: anything else, or !InRange.
- State EMPTY (no valid history):
  - Sample && InRange: Prev<=CountIn, StepCnt<=0, go ACQ.
  - Sample && !InRange: SeqError, ErrCount++, stay EMPTY.
- State ACQ:
  - HOLD: no change.
  - UP/DN matching Cand, or first step (StepCnt==0): Cand<=step dir, StepCnt++.
  - UP/DN opposite to Cand with StepCnt>0: Cand<=new dir, StepCnt<=1.
  - When the increment reaches LOCK_STEPS: go LOCKED on the same edge; Locked<=1, Dir<=Cand.
  - ILLEGAL in range: SeqError, ErrCount++, StepCnt<=0, Prev<=CountIn, stay ACQ.
  - ILLEGAL out of range: SeqError, ErrCount++, go EMPTY.
  - Prev<=CountIn on every legal sample.
- State LOCKED:
  - HOLD: no change (the counter's En=0 is legal).
  - Step in Dir: Prev update only.
  - Step opposite Dir: Dir<=new dir, DirChange pulse, stay LOCKED (the counter's Up input may toggle at any time).
  - ILLEGAL: SeqError, ErrCount++, Locked<=0, StepCnt<=0. Go ACQ (Prev<=CountIn) if InRange, else go EMPTY.
- Wrap-around steps (MAX_VAL->MIN_VAL up, MIN_VAL->MAX_VAL down) are legal steps, never errors.
- ErrCount:
  - Saturates at 2^ERRW-1.
  - ClrErr alone -> 0.
  - ClrErr with a simultaneous error -> 1.
- Sample=0: all state held, pulses low.

Test Plan:
- Reset: assert nReset=0 mid-lock -> Locked=0, Dir=1, ErrCount=0, SeqError=0 immediately. Release, then sample 3 -> state ACQ, no error.
- Up lock with wrap: samples 2,3,4,5 -> Locked=1, Dir=1 after the 4th sample edge. Then 2 (wrap) -> no SeqError. Interleaved holds 2,2 -> no change.
- Down lock, then reversal: samples 5,4,3,2,5 -> Locked=1, Dir=0, no error on 2->5. Then 2 -> Dir=1, DirChange high exactly one cycle, Locked stays 1.
- Illegal jump while locked: locked up at 2, sample 4 -> SeqError one cycle, ErrCount=1, Locked=0. Then 5,2,3 -> relock, Dir=1.
- Out of range: sample 7 while locked -> SeqError, ErrCount increments, state EMPTY. Next sample 6 -> another error. Next sample 3 -> ACQ, no error.
- Saturation and clear:
  - ERRW=2, five illegal samples -> ErrCount=3.
  - ClrErr together with an illegal sample -> ErrCount=1.
  - ClrErr alone -> 0.
  - Sample=0 with garbage CountIn -> no change.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Receive-side checker for the wrapping up/down counter bus: infers count direction,
// locks after consistent steps, and flags/counts illegal samples.
module count_seq_monitor #(
   parameter int WIDTH      = 3,
   parameter int MIN_VAL    = 2,
   parameter int MAX_VAL    = 5,
   parameter int LOCK_STEPS = 3,
   parameter int ERRW       = 8
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Sample,
   input  logic [WIDTH-1:0] CountIn,
   input  logic             ClrErr,
   output logic             Locked,
   output logic             Dir,
   output logic             DirChange,
   output logic             SeqError,
   output logic [ERRW-1:0]  ErrCount
);

   localparam logic [WIDTH-1:0] MinV    = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MaxV    = WIDTH'(MAX_VAL);
   localparam int               STEPW   = $clog2(LOCK_STEPS + 1);
   localparam logic [STEPW-1:0] LockCnt = STEPW'(LOCK_STEPS);
   localparam logic [ERRW-1:0]  ErrMax  = '1;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } stateT;

   stateT             state, stateNext;
   logic [WIDTH-1:0]  prev, prevNext;
   logic [STEPW-1:0]  stepCnt, stepNext, stepInc;
   logic              cand, candNext;
   logic              dirNext, dirChangeNext, errEvent;
   logic [ERRW-1:0]   errNext;
   logic              inRange, isHold, isUp, isDn;
   logic [WIDTH-1:0]  nxtUp, nxtDn;

   // Classify the incoming sample against the last accepted value, including wrap steps.
   always_comb begin
      inRange = (CountIn >= MinV) && (CountIn <= MaxV);
      nxtUp   = (prev == MaxV) ? MinV : prev + WIDTH'(1);
      nxtDn   = (prev == MinV) ? MaxV : prev - WIDTH'(1);
      isHold  = inRange && (CountIn == prev);
      isUp    = inRange && (CountIn == nxtUp);
      isDn    = inRange && (CountIn == nxtDn);
   end

   // Next-state logic; an opposite step during acquisition restarts the run at one.
   always_comb begin
      stateNext     = state;
      prevNext      = prev;
      stepNext      = stepCnt;
      candNext      = cand;
      dirNext       = Dir;
      dirChangeNext = 1'b0;
      errEvent      = 1'b0;
      stepInc       = '0;
      if (Sample) begin
         unique case (state)
            EMPTY: begin
               if (inRange) begin
                  prevNext  = CountIn;
                  stepNext  = '0;
                  stateNext = ACQ;
               end else begin
                  errEvent = 1'b1;
               end
            end
            ACQ: begin
               if (isHold) begin
                  stateNext = ACQ;
               end else if (isUp || isDn) begin
                  prevNext = CountIn;
                  candNext = isUp;
                  if ((stepCnt == '0) || (isUp == cand)) begin
                     stepInc = stepCnt + STEPW'(1);
                  end else begin
                     stepInc = STEPW'(1);
                  end
                  if (stepInc >= LockCnt) begin
                     stateNext = LOCKED;
                     dirNext   = isUp;
                     stepNext  = '0;
                  end else begin
                     stepNext = stepInc;
                  end
               end else begin
                  errEvent = 1'b1;
                  stepNext = '0;
                  if (inRange) begin
                     prevNext = CountIn;
                  end else begin
                     stateNext = EMPTY;
                  end
               end
            end
            LOCKED: begin
               if (isHold) begin
                  stateNext = LOCKED;
               end else if (isUp || isDn) begin
                  prevNext = CountIn;
                  if (isUp != Dir) begin
                     dirNext       = isUp;
                     dirChangeNext = 1'b1;
                  end
               end else begin
                  errEvent = 1'b1;
                  stepNext = '0;
                  if (inRange) begin
                     prevNext  = CountIn;
                     stateNext = ACQ;
                  end else begin
                     stateNext = EMPTY;
                  end
               end
            end
            default: stateNext = EMPTY;
         endcase
      end
   end

   // A clear coinciding with an error leaves the count at one so that error is not lost.
   always_comb begin
      errNext = ErrCount;
      if (errEvent) begin
         if (ClrErr) begin
            errNext = ERRW'(1);
         end else if (ErrCount != ErrMax) begin
            errNext = ErrCount + ERRW'(1);
         end
      end else if (ClrErr) begin
         errNext = '0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state     <= EMPTY;
         prev      <= MinV;
         stepCnt   <= '0;
         cand      <= 1'b1;
         Locked    <= 1'b0;
         Dir       <= 1'b1;
         DirChange <= 1'b0;
         SeqError  <= 1'b0;
         ErrCount  <= '0;
      end else begin
         state     <= stateNext;
         prev      <= prevNext;
         stepCnt   <= stepNext;
         cand      <= candNext;
         Locked    <= (stateNext == LOCKED);
         Dir       <= dirNext;
         DirChange <= dirChangeNext;
         SeqError  <= errEvent;
         ErrCount  <= errNext;
      end
   end

endmodule
